// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - LED sequencer user-side signal bundle
//
// Groups the button/pause inputs and the LED/mode/tick outputs of the LED
// pattern sequencer.
//   btn_mode : raw mode pushbutton, asynchronous, active-high
//   pause    : level, synchronous to clk; 1 freezes pattern and prescaler
//   led      : 8-bit LED bank drive (registered)
//   mode     : current pattern, 0 UP, 1 DOWN, 2 SCAN, 3 BLINK (registered)
//   tick     : one-cycle pattern-advance strobe (registered)
// The master side is the board/stimulus, the slave side is the sequencer.

interface led_pattern_sequencer_if;
    logic       btn_mode;
    logic       pause;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;

    modport master (
        output btn_mode,
        output pause,
        input  led,
        input  mode,
        input  tick
    );

    modport slave (
        input  btn_mode,
        input  pause,
        output led,
        output mode,
        output tick
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - four-pattern LED sequencer with prescaler and debounced mode button
//
// Divides clk into a pattern tick, debounces the mode button and steps the
// LED bank through count-up, count-down, bounce-scan and blink patterns.
// Ports:
//   clk  : system clock, all logic on the rising edge
//   rst  : synchronous reset, active-high
//   bus  : led_pattern_sequencer_if.slave (btn_mode, pause in; led, mode, tick out)
// Parameters:
//   DIV        : clk cycles per pattern tick (>= 2)
//   DEB_CYCLES : stable cycles needed before the debounced button changes (>= 1)

module led_pattern_sequencer #(
    parameter int DIV        = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    led_pattern_sequencer_if.slave  bus
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [PW-1:0] CNT_MAX  = PW'(DIV - 1);
    localparam logic [PW-1:0] CNT_ONE  = PW'(1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_UP    = 2'd0,
        ST_DOWN  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_BLINK = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button path: two-flop synchronizer followed by a debouncer
    // ------------------------------------------------------------------
    logic          sync1_q;
    logic          sync2_q;
    logic          deb_lvl_q;
    logic [DW-1:0] deb_cnt_q;
    logic          deb_differ;
    logic          deb_done;
    logic          press;

    assign deb_differ = (sync2_q != deb_lvl_q);
    // The counter holds DEB_CYCLES-1 on the cycle whose edge makes it reach
    // DEB_CYCLES; that edge is where the debounced level flips.
    assign deb_done   = deb_differ && (deb_cnt_q == DEB_LAST);
    // Press is combinational so the mode change lands on the very edge the
    // debounced level rises: 2 synchronizer + DEB_CYCLES cycles after the rise.
    assign press      = deb_done && sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_lvl_q <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= bus.btn_mode;
            sync2_q <= sync1_q;
            if (deb_done) begin
                deb_lvl_q <= sync2_q;
                deb_cnt_q <= '0;
            end else if (deb_differ) begin
                deb_cnt_q <= deb_cnt_q + DEB_ONE;
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern FSM, prescaler and LED register
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [7:0]    led_q,   led_d;
    logic          dir_q,   dir_d;     // scan direction: 0 left, 1 right
    logic [PW-1:0] cnt_q,   cnt_d;
    logic          tick_q,  tick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UP;
            led_q   <= 8'h00;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;

        if (press) begin
            // A press outranks a coincident tick: load the new mode's entry
            // value, drop the step and restart the prescaler.
            cnt_d = '0;
            dir_d = 1'b0;
            case (state_q)
                ST_UP: begin
                    state_d = ST_DOWN;
                    led_d   = 8'hFF;
                end
                ST_DOWN: begin
                    state_d = ST_SCAN;
                    led_d   = 8'h01;
                end
                ST_SCAN: begin
                    state_d = ST_BLINK;
                    led_d   = 8'h00;
                end
                default: begin
                    state_d = ST_UP;
                    led_d   = 8'h00;
                end
            endcase
        end else begin
            // tick_q can only be set by an unpaused cycle, so the step it
            // closes is always due.
            if (tick_q) begin
                case (state_q)
                    ST_UP:   led_d = led_q + 8'h01;
                    ST_DOWN: led_d = led_q - 8'h01;
                    ST_SCAN: begin
                        if (!dir_q) begin
                            if (led_q[7]) begin
                                led_d = 8'h40;
                                dir_d = 1'b1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d = 8'h02;
                                dir_d = 1'b0;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    default: led_d = ~led_q;
                endcase
            end

            // Pause freezes the prescaler where it is; resuming continues
            // from the held count.
            if (!bus.pause) begin
                cnt_d  = (cnt_q == CNT_MAX) ? '0 : (cnt_q + CNT_ONE);
                tick_d = (cnt_d == CNT_MAX);
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = state_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - self-checking bench for led_pattern_sequencer

module tb_led_pattern_sequencer;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    led_pattern_sequencer_if bus ();

    led_pattern_sequencer #(
        .DIV        (DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pattern described as a counter value or a lit
    // position plus bounce direction, button as a count of consecutive
    // disagreeing samples.
    // ------------------------------------------------------------------
    bit m_valid = 0;
    bit m_s1, m_s2, m_lvl;
    int m_run;
    int m_ph;
    bit m_tick;
    int m_mode;
    int m_val;
    int m_pos;
    bit m_right;

    function automatic logic [7:0] exp_led();
        if (m_mode == 2) return 8'(1 << m_pos);
        return 8'(m_val);
    endfunction

    always @(posedge clk) begin
        bit press;
        m_valid = 1;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
            m_ph = 0; m_tick = 0; m_mode = 0; m_val = 0; m_pos = 0; m_right = 0;
        end else begin
            press = (m_s2 != m_lvl) && m_s2 && (m_run + 1 == DEB);
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == DEB) begin
                    m_lvl = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus.btn_mode;

            if (press) begin
                m_mode  = (m_mode + 1) % 4;
                m_val   = (m_mode == 1) ? 255 : 0;
                m_pos   = 0;
                m_right = 0;
                m_ph    = 0;
                m_tick  = 0;
            end else begin
                if (m_tick) begin
                    case (m_mode)
                        0: m_val = (m_val + 1) % 256;
                        1: m_val = (m_val + 255) % 256;
                        2: begin
                            if (!m_right) begin
                                if (m_pos == 7) begin m_pos = 6; m_right = 1; end
                                else m_pos++;
                            end else begin
                                if (m_pos == 0) begin m_pos = 1; m_right = 0; end
                                else m_pos--;
                            end
                        end
                        default: m_val = 255 - m_val;
                    endcase
                end
                if (bus.pause) begin
                    m_tick = 0;
                end else begin
                    m_ph   = (m_ph + 1) % DIV;
                    m_tick = (m_ph == DIV - 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_led",  bus.led, exp_led());
            check("model_mode", 8'(bus.mode), 8'(m_mode));
            check("model_tick", 8'(bus.tick), 8'(m_tick));
            if (m_mode == 2) check("scan_onehot", 8'($countones(bus.led)), 8'd1);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: held 5 cycles, returns on the negedge after the press edge.
    task automatic press_btn();
        bus.btn_mode = 1'b1;
        run(5);
        bus.btn_mode = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.btn_mode = 1'b0;
        bus.pause    = 1'b0;

        // 1: reset then free running
        run(2);
        check("rst_led",  bus.led, 8'h00);
        check("rst_mode", 8'(bus.mode), 8'h00);
        check("rst_tick", 8'(bus.tick), 8'h00);
        rst = 1'b0;
        run(3);
        check("t1_tick3", 8'(bus.tick), 8'h01);
        run(1);
        check("t1_led4",  bus.led, 8'h01);
        check("t1_tick4", 8'(bus.tick), 8'h00);
        run(3);
        check("t1_tick7", 8'(bus.tick), 8'h01);
        run(1);
        check("t1_led8",  bus.led, 8'h02);
        run(2);
        check("t1_mode",  8'(bus.mode), 8'h00);

        // 2: UP wrap, then DOWN
        run(1006);
        check("t2_fe", bus.led, 8'hFE);
        run(4);
        check("t2_ff", bus.led, 8'hFF);
        run(4);
        check("t2_wrap", bus.led, 8'h00);
        press_btn();
        check("t2_mode_down", 8'(bus.mode), 8'h01);
        check("t2_entry", bus.led, 8'hFF);
        run(4);
        check("t2_dn1", bus.led, 8'hFE);
        run(4);
        check("t2_dn2", bus.led, 8'hFD);

        // 3: SCAN bounce
        run(8);
        press_btn();
        check("t3_mode_scan", 8'(bus.mode), 8'h02);
        check("t3_entry", bus.led, 8'h01);
        run(28);
        check("t3_top", bus.led, 8'h80);
        run(28);
        check("t3_bottom", bus.led, 8'h01);
        run(4);
        check("t3_turn", bus.led, 8'h02);
        run(4);
        check("t3_left", bus.led, 8'h04);

        // 4: glitch rejected, held press accepted with 5-cycle latency
        bus.btn_mode = 1'b1;
        run(2);
        bus.btn_mode = 1'b0;
        run(8);
        check("t4_glitch", 8'(bus.mode), 8'h02);
        bus.btn_mode = 1'b1;
        run(4);
        check("t4_early", 8'(bus.mode), 8'h02);
        run(1);
        check("t4_step", 8'(bus.mode), 8'h03);
        check("t4_blink_entry", bus.led, 8'h00);
        run(1);
        bus.btn_mode = 1'b0;
        run(10);
        check("t4_once", 8'(bus.mode), 8'h03);

        // 5: pause
        press_btn();
        check("t5_mode_up", 8'(bus.mode), 8'h00);
        run(20);
        check("t5_led05", bus.led, 8'h05);
        bus.pause = 1'b1;
        run(20);
        check("t5_hold", bus.led, 8'h05);
        check("t5_notick", 8'(bus.tick), 8'h00);
        press_btn();
        check("t5_pause_press", 8'(bus.mode), 8'h01);
        check("t5_pause_entry", bus.led, 8'hFF);
        bus.pause = 1'b0;
        run(4);
        check("t5_resume", bus.led, 8'hFE);

        // 6: press on a tick in BLINK, reset mid-debounce, button held through reset
        run(8);
        press_btn();
        check("t6_scan", 8'(bus.mode), 8'h02);
        run(8);
        press_btn();
        check("t6_blink", 8'(bus.mode), 8'h03);
        run(3);
        bus.btn_mode = 1'b1;
        run(4);
        check("t6_tick_cycle", 8'(bus.tick), 8'h01);
        check("t6_blink_on", bus.led, 8'hFF);
        run(1);
        check("t6_press_wins_mode", 8'(bus.mode), 8'h00);
        check("t6_press_wins_led", bus.led, 8'h00);
        check("t6_press_wins_tick", 8'(bus.tick), 8'h00);
        bus.btn_mode = 1'b0;
        run(8);
        bus.btn_mode = 1'b1;
        run(3);
        rst = 1'b1;
        run(1);
        check("t6_rst_led",  bus.led, 8'h00);
        check("t6_rst_mode", 8'(bus.mode), 8'h00);
        check("t6_rst_tick", 8'(bus.tick), 8'h00);
        run(2);
        rst = 1'b0;
        run(4);
        check("t6_held_early", 8'(bus.mode), 8'h00);
        run(1);
        check("t6_held_press", 8'(bus.mode), 8'h01);
        run(10);
        check("t6_held_once", 8'(bus.mode), 8'h01);
        bus.btn_mode = 1'b0;
        run(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
